regfile_dumper: RTL and testbench

REGFILE_DUMPER -- requirements
Module: regfile_dumper

---
 rtl/regfile_dumper_pkg.sv | 16 +
 rtl/regfile_dumper.sv | 147 ++++++++++++++
 tb/tb_regfile_dumper.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_dumper_pkg.sv
// Shared types and defaults for the register-file dumper.
package regfile_dumper_pkg;

    localparam int DATA_W        = 32;
    localparam int DEFAULT_NREGS = 32;
    localparam int DEFAULT_AW    = 5;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        SEND,
        SUM,
        FIN
    } dump_state_e;

endpackage

// File: rtl/regfile_dumper.sv
// Walks a register file through its combinational read port and streams each word
// out over a valid/ready link. Optional trailing XOR checksum beat under DUMP_CHECKSUM_EN.
module regfile_dumper
    import regfile_dumper_pkg::*;
#(
    parameter int NREGS = DEFAULT_NREGS,
    parameter int AW    = DEFAULT_AW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic [AW-1:0]     rf_addr,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [AW-1:0]     out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sum,
    output logic              busy,
    output logic              done
);

    dump_state_e       state, state_nxt;
    logic [AW-1:0]     index, index_nxt;
    logic              valid_nxt;
    logic [AW-1:0]     addr_nxt;
    logic [DATA_W-1:0] data_nxt;
    logic              handshake;
    logic              last;
`ifdef DUMP_CHECKSUM_EN
    logic [DATA_W-1:0] checksum, checksum_nxt;
    logic              sum_nxt;
`endif

    assign handshake = out_valid && out_ready;
    assign last      = (index == AW'(NREGS - 1));
    assign rf_addr   = index;
    assign busy      = (state != IDLE);
    assign done      = (state == FIN);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            index     <= '0;
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_data  <= '0;
`ifdef DUMP_CHECKSUM_EN
            checksum  <= '0;
            out_sum   <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            index     <= index_nxt;
            out_valid <= valid_nxt;
            out_addr  <= addr_nxt;
            out_data  <= data_nxt;
`ifdef DUMP_CHECKSUM_EN
            checksum  <= checksum_nxt;
            out_sum   <= sum_nxt;
`endif
        end
    end

`ifndef DUMP_CHECKSUM_EN
    assign out_sum = 1'b0;
`endif

    // Abort is applied last so it overrides any handshake decided above it.
    always_comb begin
        state_nxt = state;
        index_nxt = index;
        valid_nxt = out_valid;
        addr_nxt  = out_addr;
        data_nxt  = out_data;
`ifdef DUMP_CHECKSUM_EN
        checksum_nxt = checksum;
        sum_nxt      = out_sum;
`endif
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_nxt = READ;
                    index_nxt = '0;
`ifdef DUMP_CHECKSUM_EN
                    checksum_nxt = '0;
`endif
                end
            end
            READ: begin
                addr_nxt  = index;
                data_nxt  = rf_rdata;
                valid_nxt = 1'b1;
                state_nxt = SEND;
`ifdef DUMP_CHECKSUM_EN
                checksum_nxt = checksum ^ rf_rdata;
`endif
            end
            SEND: begin
                if (handshake) begin
                    valid_nxt = 1'b0;
                    if (!last) begin
                        index_nxt = index + AW'(1);
                        state_nxt = READ;
                    end else begin
`ifdef DUMP_CHECKSUM_EN
                        state_nxt = SUM;
                        valid_nxt = 1'b1;
                        sum_nxt   = 1'b1;
                        addr_nxt  = '0;
                        data_nxt  = checksum;
`else
                        state_nxt = FIN;
`endif
                    end
                end
            end
            SUM: begin
`ifdef DUMP_CHECKSUM_EN
                if (handshake) begin
                    valid_nxt = 1'b0;
                    sum_nxt   = 1'b0;
                    state_nxt = FIN;
                end
`else
                state_nxt = IDLE;
`endif
            end
            FIN: begin
                state_nxt = IDLE;
                index_nxt = '0;
            end
            default: state_nxt = IDLE;
        endcase

        if (abort && (state != IDLE)) begin
            state_nxt = IDLE;
            index_nxt = '0;
            valid_nxt = 1'b0;
`ifdef DUMP_CHECKSUM_EN
            sum_nxt   = 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_regfile_dumper.sv
// Scoreboard bench for regfile_dumper; expects a checksum beat when DUMP_CHECKSUM_EN is defined.
module tb_regfile_dumper;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
        logic        sum;
    } beat_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [4:0]  rf_addr;
    logic [31:0] rf_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_addr;
    logic [31:0] out_data;
    logic        out_sum;
    logic        busy;
    logic        done;

    logic [31:0] rf_mem [32];
    beat_t       beat_q [$];
    int          checks = 0;
    int          passed = 0;

    regfile_dumper #(.NREGS(32), .AW(5)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .rf_addr(rf_addr), .rf_rdata(rf_rdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .out_data(out_data), .out_sum(out_sum),
        .busy(busy), .done(done)
    );

    assign rf_rdata = rf_mem[rf_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic load_expected();
        logic [31:0] x = '0;
        beat_q.delete();
        for (int i = 0; i < 32; i++) begin
            beat_q.push_back('{addr: 5'(i), data: rf_mem[i], sum: 1'b0});
            x ^= rf_mem[i];
        end
`ifdef DUMP_CHECKSUM_EN
        beat_q.push_back('{addr: 5'd0, data: x, sum: 1'b1});
`endif
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b1; abort = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({out_valid, out_addr, out_data, out_sum, busy, done, rf_addr} !== '0)
            $display("[TB] FAIL reset_outputs valid=%0b addr=%0d data=%h sum=%0b busy=%0b done=%0b rf_addr=%0d required all 0",
                     out_valid, out_addr, out_data, out_sum, busy, done, rf_addr);
        else passed++;
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) $display("[TB] FAIL reset_start_ignored busy=%0b required 0", busy);
        else passed++;
    endtask

    task automatic test_full_dump();
        int    done_cnt = 0;
        int    done_cyc = -1;
        int    hs_cyc   = -1;
        beat_t exp;
        load_expected();
        out_ready = 1'b1;
        pulse_start();
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (done) begin done_cnt++; done_cyc = c; end
            if (out_valid && out_ready) begin
                hs_cyc = c;
                checks++;
                if (beat_q.size() == 0) begin
                    $display("[TB] FAIL full_extra_beat addr=%0d sum=%0b required no beat", out_addr, out_sum);
                end else begin
                    exp = beat_q.pop_front();
                    if ({out_addr, out_data, out_sum} !== {exp.addr, exp.data, exp.sum})
                        $display("[TB] FAIL full_beat got addr=%0d data=%h sum=%0b required addr=%0d data=%h sum=%0b",
                                 out_addr, out_data, out_sum, exp.addr, exp.data, exp.sum);
                    else passed++;
                end
            end
            if (done_cnt > 0 && c > done_cyc + 3) break;
        end
        checks++;
        if (beat_q.size() != 0) $display("[TB] FAIL full_missing_beats left=%0d required 0", beat_q.size());
        else passed++;
        checks++;
        if (done_cnt != 1) $display("[TB] FAIL full_done_count got %0d required 1", done_cnt);
        else passed++;
        checks++;
        if (done_cyc != hs_cyc + 1) $display("[TB] FAIL full_done_timing got cycle %0d required %0d", done_cyc, hs_cyc + 1);
        else passed++;
        checks++;
        if ({busy, rf_addr, out_valid} !== '0)
            $display("[TB] FAIL full_idle_after busy=%0b rf_addr=%0d valid=%0b required 0/0/0", busy, rf_addr, out_valid);
        else passed++;
    endtask

    task automatic test_backpressure();
        int    stall    = 0;
        int    done_cnt = 0;
        beat_t exp;
        load_expected();
        out_ready = 1'b1;
        pulse_start();
        for (int c = 0; c < 200 && !(done_cnt > 0 && beat_q.size() == 0); c++) begin
            @(negedge clk);
            if (done) done_cnt++;
            if (out_valid && !out_sum && out_addr == 5'd9 && stall < 3) begin
                out_ready = 1'b0;
                checks++;
                if ({out_valid, out_addr, out_data} !== {1'b1, 5'd9, 32'h20})
                    $display("[TB] FAIL stall_hold valid=%0b addr=%0d data=%h required 1/9/00000020", out_valid, out_addr, out_data);
                else passed++;
                stall++;
            end else begin
                out_ready = 1'b1;
            end
            if (out_valid && out_ready) begin
                checks++;
                if (beat_q.size() == 0) begin
                    $display("[TB] FAIL stall_extra_beat addr=%0d required no beat", out_addr);
                end else begin
                    exp = beat_q.pop_front();
                    if ({out_addr, out_data, out_sum} !== {exp.addr, exp.data, exp.sum})
                        $display("[TB] FAIL stall_beat got addr=%0d data=%h sum=%0b required addr=%0d data=%h sum=%0b",
                                 out_addr, out_data, out_sum, exp.addr, exp.data, exp.sum);
                    else passed++;
                end
            end
        end
        out_ready = 1'b1;
        checks++;
        if (stall != 3) $display("[TB] FAIL stall_cycles got %0d required 3", stall);
        else passed++;
        checks++;
        if (beat_q.size() != 0 || done_cnt != 1)
            $display("[TB] FAIL stall_complete left=%0d done=%0d required 0/1", beat_q.size(), done_cnt);
        else passed++;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_abort();
        int found    = 0;
        int done_cnt = 0;
        out_ready = 1'b1;
        abort = 1'b1; start = 1'b1;
        @(negedge clk);
        abort = 1'b0; start = 1'b0;
        checks++;
        if (busy !== 1'b0) $display("[TB] FAIL abort_beats_start_idle busy=%0b required 0", busy);
        else passed++;
        pulse_start();
        for (int c = 0; c < 40 && found == 0; c++) begin
            @(negedge clk);
            if (out_valid && out_addr == 5'd5) found = 1;
        end
        checks++;
        if (found != 1) $display("[TB] FAIL abort_reach_beat5 found=%0d required 1", found);
        else passed++;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if ({busy, out_valid, done} !== 3'b000)
            $display("[TB] FAIL abort_idle busy=%0b valid=%0b done=%0b required 0/0/0", busy, out_valid, done);
        else passed++;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (done || busy) done_cnt++;
        end
        checks++;
        if (done_cnt != 0) $display("[TB] FAIL abort_no_done active_cycles=%0d required 0", done_cnt);
        else passed++;
        pulse_start();
        found = 0;
        for (int c = 0; c < 10 && found == 0; c++) begin
            @(negedge clk);
            if (out_valid) found = 1;
        end
        checks++;
        if ({found[0], out_addr, out_data, out_sum} !== {1'b1, 5'd0, rf_mem[0], 1'b0})
            $display("[TB] FAIL abort_restart valid=%0d addr=%0d data=%h sum=%0b required 1/0/%h/0",
                     found, out_addr, out_data, out_sum, rf_mem[0]);
        else passed++;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
    endtask

    task automatic test_reset_mid();
        int found  = 0;
        int active = 0;
        out_ready = 1'b1;
        pulse_start();
        for (int c = 0; c < 60 && found == 0; c++) begin
            @(negedge clk);
            if (out_valid && out_addr == 5'd12) found = 1;
        end
        checks++;
        if (found != 1) $display("[TB] FAIL rst_reach_beat12 found=%0d required 1", found);
        else passed++;
        rst_n = 1'b0;
        start = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
        checks++;
        if ({out_valid, out_addr, out_data, out_sum, busy, done, rf_addr} !== '0)
            $display("[TB] FAIL rst_mid_outputs valid=%0b addr=%0d data=%h sum=%0b busy=%0b done=%0b rf_addr=%0d required all 0",
                     out_valid, out_addr, out_data, out_sum, busy, done, rf_addr);
        else passed++;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (done || busy) active++;
        end
        checks++;
        if (active != 0) $display("[TB] FAIL rst_mid_no_done active_cycles=%0d required 0", active);
        else passed++;
    endtask

    task automatic test_start_ignored();
        int    done_cnt = 0;
        int    pulsed   = 0;
        beat_t exp;
        load_expected();
        out_ready = 1'b1;
        pulse_start();
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) done_cnt++;
            if (out_valid && out_addr == 5'd20 && pulsed == 0) begin
                start = 1'b1;
                pulsed = 1;
            end
            if (out_valid && out_ready) begin
                checks++;
                if (beat_q.size() == 0) begin
                    $display("[TB] FAIL busy_start_extra_beat addr=%0d required no beat", out_addr);
                end else begin
                    exp = beat_q.pop_front();
                    if ({out_addr, out_data, out_sum} !== {exp.addr, exp.data, exp.sum})
                        $display("[TB] FAIL busy_start_beat got addr=%0d data=%h sum=%0b required addr=%0d data=%h sum=%0b",
                                 out_addr, out_data, out_sum, exp.addr, exp.data, exp.sum);
                    else passed++;
                end
            end
            if (done_cnt > 0 && !busy && c > 80) break;
        end
        start = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        checks++;
        if (beat_q.size() != 0 || done_cnt != 1 || busy !== 1'b0)
            $display("[TB] FAIL busy_start_complete left=%0d done=%0d busy=%0b required 0/1/0", beat_q.size(), done_cnt, busy);
        else passed++;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf_mem[i] = 32'h0;
        rf_mem[6] = 32'h40;
        rf_mem[9] = 32'h20;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_full_dump();
        test_backpressure();
        test_abort();
        test_reset_mid();
        test_start_ignored();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
